// File: rtl/showcase0_result_packer_if.sv
// Producer/consumer bundle for the result packer. The DUT takes the slave side
// and the environment takes the master side.
interface showcase0_result_packer_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 in_vld;
    logic [31:0]          c;
    logic                 cmp_5;
    logic [7:0]           sc_signal;
    logic [7:0]           j;
    logic [7:0]           g;
    logic [7:0]           h;
    logic [31:0]          out_data;
    logic                 out_vld;
    logic                 out_rd;
    logic                 in_drop;
    logic [CNT_WIDTH-1:0] match_cnt;
    logic [31:0]          sum_acc;
    logic [LW-1:0]        level;

    modport slave (
        input  in_vld, c, cmp_5, sc_signal, j, g, h, out_rd,
        output out_data, out_vld, in_drop, match_cnt, sum_acc, level
    );

    modport master (
        output in_vld, c, cmp_5, sc_signal, j, g, h, out_rd,
        input  out_data, out_vld, in_drop, match_cnt, sum_acc, level
    );
endinterface

// File: rtl/showcase0_result_packer.sv
// Packs upstream results into 32-bit words and queues them in a small
// first-word-fall-through buffer, with match counting and a running sum.
module showcase0_result_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    showcase0_result_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q;
    logic                 drop_q;
    logic [CNT_WIDTH-1:0] match_q;
    logic [31:0]          sum_q;

    logic        empty, pop, push;
    logic [31:0] word;

    assign empty = (level_q == '0);
    assign pop   = !empty && bus.out_rd;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push  = bus.in_vld && ((level_q < LW'(FIFO_DEPTH)) || pop);
    assign word  = {bus.sc_signal, bus.j, bus.g, bus.h};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= 1'b0;
            match_q <= '0;
            sum_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            drop_q  <= bus.in_vld && !push;
            if (bus.in_vld && bus.cmp_5 && (match_q != '1))
                match_q <= match_q + CNT_WIDTH'(1);
            if (push) sum_q <= sum_q + bus.c;
        end
    end

    // Storage is not reset; the empty-gated output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= word;
    end

    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
    assign bus.out_vld   = !empty;
    assign bus.in_drop   = drop_q;
    assign bus.match_cnt = match_q;
    assign bus.sum_acc   = sum_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_showcase0_result_packer.sv
// Randomized + directed bench for the result packer; a scoreboard queue of
// expected words is checked by an independent mid-cycle monitor.
module tb_showcase0_result_packer;
    localparam int D  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    showcase0_result_packer_if #(.FIFO_DEPTH(D), .CNT_WIDTH(CW)) bus ();

    showcase0_result_packer #(.FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          m_level = 0;
    logic        m_drop  = 1'b0;
    int          m_match = 0;
    logic [31:0] m_sum   = '0;
    bit          m_zero  = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Mid-cycle: inputs and outputs are both settled; a handshake seen here
    // completes at the next rising edge.
    always @(negedge clk) begin
        chk("level", 32'(bus.level), 32'(m_level));
        chk("out_vld", 32'(bus.out_vld), 32'(m_level > 0));
        chk("in_drop", 32'(bus.in_drop), 32'(m_drop));
        chk("match_cnt", 32'(bus.match_cnt), 32'(m_match));
        chk("sum_acc", bus.sum_acc, m_sum);
        if (m_level > 0 && exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
        else if (m_level == 0 && m_zero)     chk("out_data_reset", bus.out_data, 32'h0);
        if (rst_n && bus.out_vld && bus.out_rd) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got 0x%08h expected no word", bus.out_data);
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Drives one cycle of stimulus and predicts the state after the edge.
    task automatic drive(input bit rst, input bit vld, input bit rd, input logic [31:0] cv,
                         input bit cmp, input logic [7:0] s, jj, gg, hh);
        bit pop, acc;
        int n_level, n_match;
        logic [31:0] n_sum;
        bit n_drop, n_zero;
        rst_n = !rst; bus.in_vld = vld; bus.out_rd = rd; bus.c = cv; bus.cmp_5 = cmp;
        bus.sc_signal = s; bus.j = jj; bus.g = gg; bus.h = hh;
        if (rst) begin
            exp_q.delete();
            n_level = 0; n_match = 0; n_sum = '0; n_drop = 0; n_zero = 1;
        end else begin
            pop     = (m_level > 0) && rd;
            acc     = vld && (m_level < D || pop);
            n_level = m_level + int'(acc) - int'(pop);
            n_sum   = acc ? m_sum + cv : m_sum;
            n_drop  = vld && !acc;
            n_match = (vld && cmp) ? ((m_match < (1 << CW) - 1) ? m_match + 1 : m_match) : m_match;
            n_zero  = m_zero && !acc;
            if (acc) exp_q.push_back({s, jj, gg, hh});
        end
        @(posedge clk);
        #2;
        m_level = n_level; m_sum = n_sum; m_drop = n_drop; m_match = n_match; m_zero = n_zero;
    endtask

    task automatic idle(input bit rd);
        drive(1'b0, 1'b0, rd, 32'h0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        do_reset();
        do_reset();

        // Single sample
        drive(0, 1, 0, 32'd5, 0, 8'h04, 8'h01, 8'h22, 8'h02);
        chk("single_word", bus.out_data, 32'h04012202);
        idle(0);

        // Fill then overflow
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(0, 1, 0, 32'(10 + i), 1, 8'(i), 8'h11, 8'h22, 8'(i));
        chk("ovf_sum", bus.sum_acc, 32'd46);
        idle(0);
        idle(0);

        // Full with simultaneous push and pop
        drive(0, 1, 1, 32'd100, 0, 8'hF0, 8'h0F, 8'h5A, 8'hA5);
        drive(0, 1, 1, 32'd200, 0, 8'hF1, 8'h1F, 8'h5B, 8'hA6);
        idle(0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 32'h0, 1, 8'h0, 8'h0, 8'h0, 8'(i));
        chk("sat_cnt", 32'(bus.match_cnt), 32'd3);
        idle(1);

        // Wrap: ten push/pop pairs with all-ones c
        do_reset();
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 32'hFFFF_FFFF, 0, 8'h0, 8'h0, 8'h0, 8'(i));
        chk("wrap_sum", bus.sum_acc, 32'hFFFF_FFF6);
        idle(1);
        idle(1);

        // Reset mid-stream, then a lone push
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 32'd7, 1, 8'h3C, 8'h00, 8'h00, 8'(i));
        do_reset();
        drive(0, 1, 0, 32'd9, 0, 8'h12, 8'h34, 8'h56, 8'h78);
        chk("post_reset_word", bus.out_data, 32'h12345678);
        idle(1);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else drive(0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                       $urandom, 1'($urandom_range(0, 3) == 0),
                       8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < D + 2; i++) idle(1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/showcase0_result_packer.md
SHOWCASE0_RESULT_PACKER -- requirements
Module: showcase0_result_packer

Interface
REQ-001 SHALL provide parameter: FIFO_DEPTH, default 4, result buffer entries (power of two, >=2).
REQ-002 SHALL provide parameter: CNT_WIDTH, default 16, width of match_cnt.
REQ-003 SHALL provide port: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL provide port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL provide port: in_vld  in  1  sample strobe; upstream results valid this cycle.
REQ-006 SHALL provide port: c  in  32  upstream sum result.
REQ-007 SHALL provide port: cmp_5  in  1  upstream equality flag (b == 4).
REQ-008 SHALL provide port: sc_signal  in  8  upstream case-decoded value.
REQ-009 SHALL provide port: j  in  8  upstream ROM read value.
REQ-010 SHALL provide port: g  in  8  upstream bit-concatenation result.
REQ-011 SHALL provide port: h  in  8  upstream conditional result.
REQ-012 SHALL provide port: out_data  out  32  packed word at buffer head.
REQ-013 SHALL provide port: out_vld  out  1  buffer non-empty.
REQ-014 SHALL provide port: out_rd  in  1  consumer ready; pop when out_vld && out_rd.
REQ-015 SHALL provide port: in_drop  out  1  one-cycle pulse, sample lost (buffer full).
REQ-016 SHALL provide port: match_cnt  out  CNT_WIDTH  count of sampled cmp_5 events.
REQ-017 SHALL provide port: sum_acc  out  32  running sum of c over accepted samples.
REQ-018 SHALL provide port: level  out  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-019 Packed word SHALL be {sc_signal, j, g, h}, sc_signal in bits 31:24, h in bits 7:0.
REQ-020 Push SHALL occur when in_vld && (level < FIFO_DEPTH || pop this cycle).
REQ-021 Buffer SHALL be first-word-fall-through: out_data valid whenever out_vld = 1, no read latency.
REQ-022 Push into empty buffer SHALL raise out_vld on the next cycle (1-cycle latency), out_data = pushed word.
REQ-023 Pop SHALL advance head; out_data SHALL show the next entry in the following cycle if level > 1.
REQ-024 Simultaneous push and pop SHALL leave level unchanged, including when full and when level = 1.
REQ-025 in_vld with buffer full and no pop SHALL discard the sample and assert in_drop for exactly the next cycle.
REQ-026 Dropped samples SHALL NOT update sum_acc; match_cnt SHALL still count them.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be 0..FIFO_DEPTH inclusive.
REQ-028 out_rd with out_vld = 0 SHALL be ignored (no pointer or level change).
REQ-029 match_cnt SHALL increment by 1 on each cycle with in_vld && cmp_5, saturating at 2^CNT_WIDTH-1.
REQ-030 sum_acc SHALL add c on each accepted push, wrapping modulo 2^32.
REQ-031 out_data SHALL be stable while out_vld && !out_rd.
REQ-032 Inputs other than in_vld and out_rd SHALL be ignored when their qualifier is low.

Reset
REQ-033 While rst_n = 0 at a rising clk edge: level = 0, out_vld = 0, in_drop = 0, match_cnt = 0, sum_acc = 0, pointers = 0.
REQ-034 out_data SHALL be 0 after reset until first push; buffer storage need not be cleared.
REQ-035 Reset mid-operation SHALL discard all buffered words; in_vld/out_rd in the reset cycle SHALL have no effect.
REQ-036 First push SHALL be accepted in the first cycle with rst_n = 1.

Verification
REQ-037 Single sample: in_vld=1, sc=0x04, j=0x01, g=0x22, h=0x02, c=5, out_rd=0 -> next cycle out_vld=1, out_data=0x04012202, level=1, sum_acc=5.
REQ-038 Fill and overflow: 5 consecutive in_vld, out_rd=0, depth 4 -> level=4, 5th sample dropped, in_drop high 1 cycle, sum_acc = sum of first 4 c.
REQ-039 Full with simultaneous pop: level=4, in_vld=1 and out_rd=1 same cycle -> no drop, level stays 4, oldest word removed, new word at tail.
REQ-040 Saturation: CNT_WIDTH=2, 5 cycles in_vld=1, cmp_5=1 -> match_cnt 1,2,3,3,3.
REQ-041 Wrap: 10 push/pop pairs with incrementing h=0..9 -> out_data h order 0..9, no drops, sum_acc wraps correctly with c=0xFFFFFFFF.
REQ-042 Reset mid-stream: level=3, rst_n=0 one cycle -> out_vld=0, level=0, counters 0; following push appears as sole entry.
